// File: rtl/skin_centroid_tracker.sv
// skin_centroid_tracker: streaming R-G skin mask plus per-frame centroid.
// First moments are accumulated over each frame. At end of frame a single
// shared restoring divider produces cen_x, cen_y and the skin pixel count.
// Optional macro SKIN_BBOX_EN adds per-frame bounding-box outputs.
module skin_centroid_tracker #(
    parameter int H_ACTIVE  = 640,
    parameter int V_ACTIVE  = 480,
    parameter int DATA_W    = 8,
    parameter int MIN_COUNT = 64,
    localparam int X_W      = $clog2(H_ACTIVE),
    localparam int Y_W      = $clog2(V_ACTIVE),
    localparam int CNT_W    = $clog2(H_ACTIVE*V_ACTIVE+1)
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     pix_valid,
    input  logic                     sof,
    input  logic [DATA_W-1:0]        R,
    input  logic [DATA_W-1:0]        G,
    input  logic [DATA_W-1:0]        B,
    input  logic signed [DATA_W:0]   thr_lo,
    input  logic signed [DATA_W:0]   thr_hi,
    output logic                     mask,
    output logic                     mask_valid,
    output logic [X_W-1:0]           cen_x,
    output logic [Y_W-1:0]           cen_y,
    output logic [CNT_W-1:0]         pix_count,
    output logic                     found,
    output logic                     result_valid,
    output logic                     busy,
    output logic                     frame_drop
`ifdef SKIN_BBOX_EN
    ,
    output logic [X_W-1:0]           bb_xmin,
    output logic [X_W-1:0]           bb_xmax,
    output logic [Y_W-1:0]           bb_ymin,
    output logic [Y_W-1:0]           bb_ymax
`endif
);
    localparam int SX_W   = X_W + CNT_W;
    localparam int SY_W   = Y_W + CNT_W;
    localparam int DIV_W  = (SX_W > SY_W) ? SX_W : SY_W;
    localparam int STEP_W = $clog2(DIV_W);

    localparam logic [X_W-1:0]    COL_LAST = X_W'(H_ACTIVE-1);
    localparam logic [Y_W-1:0]    ROW_LAST = Y_W'(V_ACTIVE-1);
    localparam logic [CNT_W:0]    MIN_CNT  = (CNT_W+1)'(MIN_COUNT);
    localparam logic [STEP_W-1:0] X_LAST   = STEP_W'(SX_W-1);
    localparam logic [STEP_W-1:0] Y_LAST   = STEP_W'(SY_W-1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CHECK = 3'd1;
    localparam logic [2:0] S_DIV_X = 3'd2;
    localparam logic [2:0] S_DIV_Y = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    // One restoring step: shift in a dividend bit, subtract if it fits.
    // Returns {quotient bit, new remainder}.
    function automatic logic [CNT_W:0] div_step(input logic [CNT_W-1:0] r,
                                                input logic b,
                                                input logic [CNT_W-1:0] d);
        logic [CNT_W:0] t;
        t = {r, b};
        if (t >= {1'b0, d}) div_step = {1'b1, CNT_W'(t - {1'b0, d})};
        else                div_step = {1'b0, t[CNT_W-1:0]};
    endfunction

    logic [X_W-1:0]           col, pix_col;
    logic [Y_W-1:0]           row, pix_row;
    logic                     at_origin, last_col, last_row, eof, skin;
    logic signed [DATA_W:0]   thr_lo_q, thr_hi_q, lo_eff, hi_eff, diff;
    logic [SX_W-1:0]          sum_x, sum_x_nxt, div_sx;
    logic [SY_W-1:0]          sum_y, sum_y_nxt, div_sy;
    logic [CNT_W-1:0]         cnt, cnt_nxt, div_cnt, rem;
    logic [2:0]               state;
    logic                     hit;
    logic [DIV_W-1:0]         dvd, dvd_shift;
    logic [STEP_W-1:0]        step;
    logic [CNT_W:0]           step_res;
    logic [X_W-1:0]           qx;
    logic [Y_W-1:0]           qy;
    logic                     unused_b;

    // B is reserved for future colour modes.
    assign unused_b  = ^B;

    // sof relocates the current pixel to (0,0) regardless of the counters.
    assign pix_col   = sof ? '0 : col;
    assign pix_row   = sof ? '0 : row;
    assign at_origin = (pix_col == '0) && (pix_row == '0);
    assign last_col  = (pix_col == COL_LAST);
    assign last_row  = (pix_row == ROW_LAST);
    assign eof       = pix_valid && last_col && last_row;

    // The origin pixel is judged against the thresholds it latches.
    assign lo_eff    = at_origin ? thr_lo : thr_lo_q;
    assign hi_eff    = at_origin ? thr_hi : thr_hi_q;
    assign diff      = $signed({1'b0, R}) - $signed({1'b0, G});
    assign skin      = pix_valid && (diff > lo_eff) && (diff < hi_eff);

    assign busy      = (state != S_IDLE);
    assign step_res  = div_step(rem, dvd[DIV_W-1], div_cnt);
    assign dvd_shift = {dvd[DIV_W-2:0], step_res[CNT_W]};

    // Moment update for this pixel; sof drops any partial frame first.
    always_comb begin
        sum_x_nxt = sof ? '0 : sum_x;
        sum_y_nxt = sof ? '0 : sum_y;
        cnt_nxt   = sof ? '0 : cnt;
        if (skin) begin
            sum_x_nxt = sum_x_nxt + SX_W'(pix_col);
            sum_y_nxt = sum_y_nxt + SY_W'(pix_row);
            cnt_nxt   = cnt_nxt + 1'b1;
        end
    end

    // Position counters advance only on accepted pixels.
    always_ff @(posedge clock) begin
        if (reset) begin
            col <= '0;
            row <= '0;
        end else if (pix_valid) begin
            if (last_col) begin
                col <= '0;
                row <= last_row ? '0 : pix_row + 1'b1;
            end else begin
                col <= pix_col + 1'b1;
                row <= pix_row;
            end
        end
    end

    // Thresholds are frozen for the frame at every accepted origin pixel.
    always_ff @(posedge clock) begin
        if (reset) begin
            thr_lo_q <= '0;
            thr_hi_q <= '0;
        end else if (pix_valid && at_origin) begin
            thr_lo_q <= thr_lo;
            thr_hi_q <= thr_hi;
        end
    end

    // Registered mask; holds its value across pixel gaps.
    always_ff @(posedge clock) begin
        if (reset) begin
            mask       <= 1'b0;
            mask_valid <= 1'b0;
        end else begin
            mask_valid <= pix_valid;
            if (pix_valid) mask <= skin;
        end
    end

    // Frame accumulators: cleared at EOF whether or not the frame is kept.
    always_ff @(posedge clock) begin
        if (reset || eof) begin
            sum_x <= '0;
            sum_y <= '0;
            cnt   <= '0;
        end else if (pix_valid) begin
            sum_x <= sum_x_nxt;
            sum_y <= sum_y_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Snapshot, shared divider FSM and result registers. Rejected frames
    // publish straight out of CHECK; valid ones publish out of DONE.
    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= S_IDLE;
            hit          <= 1'b0;
            div_sx       <= '0;
            div_sy       <= '0;
            div_cnt      <= '0;
            dvd          <= '0;
            rem          <= '0;
            step         <= '0;
            qx           <= '0;
            qy           <= '0;
            cen_x        <= '0;
            cen_y        <= '0;
            pix_count    <= '0;
            found        <= 1'b0;
            result_valid <= 1'b0;
            frame_drop   <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            frame_drop   <= eof && busy;
            if (eof && !busy) begin
                div_sx  <= sum_x_nxt;
                div_sy  <= sum_y_nxt;
                div_cnt <= cnt_nxt;
            end
            case (state)
                S_IDLE: if (eof) state <= S_CHECK;
                S_CHECK: begin
                    if (({1'b0, div_cnt} < MIN_CNT) || (div_cnt == '0)) begin
                        hit          <= 1'b0;
                        pix_count    <= div_cnt;
                        found        <= 1'b0;
                        result_valid <= 1'b1;
                        state        <= S_DONE;
                    end else begin
                        hit   <= 1'b1;
                        dvd   <= DIV_W'(div_sx) << (DIV_W - SX_W);
                        rem   <= '0;
                        step  <= '0;
                        state <= S_DIV_X;
                    end
                end
                S_DIV_X: begin
                    rem  <= step_res[CNT_W-1:0];
                    step <= step + 1'b1;
                    dvd  <= dvd_shift;
                    if (step == X_LAST) begin
                        qx    <= dvd_shift[X_W-1:0];
                        dvd   <= DIV_W'(div_sy) << (DIV_W - SY_W);
                        rem   <= '0;
                        step  <= '0;
                        state <= S_DIV_Y;
                    end
                end
                S_DIV_Y: begin
                    rem  <= step_res[CNT_W-1:0];
                    step <= step + 1'b1;
                    dvd  <= dvd_shift;
                    if (step == Y_LAST) begin
                        qy    <= dvd_shift[Y_W-1:0];
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (hit) begin
                        cen_x        <= qx;
                        cen_y        <= qy;
                        pix_count    <= div_cnt;
                        found        <= 1'b1;
                        result_valid <= 1'b1;
                    end
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef SKIN_BBOX_EN
    logic [X_W-1:0] bx_min, bx_max, bx_min_nxt, bx_max_nxt, snap_xmin, snap_xmax;
    logic [Y_W-1:0] by_min, by_max, by_min_nxt, by_max_nxt, snap_ymin, snap_ymax;

    // Bounding-box update; trackers restart at the origin pixel.
    always_comb begin
        bx_min_nxt = at_origin ? COL_LAST : bx_min;
        bx_max_nxt = at_origin ? '0 : bx_max;
        by_min_nxt = at_origin ? ROW_LAST : by_min;
        by_max_nxt = at_origin ? '0 : by_max;
        if (skin) begin
            if (pix_col < bx_min_nxt) bx_min_nxt = pix_col;
            if (pix_col > bx_max_nxt) bx_max_nxt = pix_col;
            if (pix_row < by_min_nxt) by_min_nxt = pix_row;
            if (pix_row > by_max_nxt) by_max_nxt = pix_row;
        end
    end

    // Per-frame box trackers.
    always_ff @(posedge clock) begin
        if (reset) begin
            bx_min <= '0;
            bx_max <= '0;
            by_min <= '0;
            by_max <= '0;
        end else if (pix_valid) begin
            bx_min <= bx_min_nxt;
            bx_max <= bx_max_nxt;
            by_min <= by_min_nxt;
            by_max <= by_max_nxt;
        end
    end

    // Box snapshot at EOF and publication alongside the centroid.
    always_ff @(posedge clock) begin
        if (reset) begin
            snap_xmin <= '0;
            snap_xmax <= '0;
            snap_ymin <= '0;
            snap_ymax <= '0;
            bb_xmin   <= '0;
            bb_xmax   <= '0;
            bb_ymin   <= '0;
            bb_ymax   <= '0;
        end else begin
            if (eof && !busy) begin
                snap_xmin <= bx_min_nxt;
                snap_xmax <= bx_max_nxt;
                snap_ymin <= by_min_nxt;
                snap_ymax <= by_max_nxt;
            end
            if (state == S_DONE && hit) begin
                bb_xmin <= snap_xmin;
                bb_xmax <= snap_xmax;
                bb_ymin <= snap_ymin;
                bb_ymax <= snap_ymax;
            end
        end
    end
`endif

endmodule

// File: tb/tb_skin_centroid_tracker.sv
// Randomized bench for skin_centroid_tracker (5x3 frames, MIN_COUNT=3).
// A frame-level reference model predicts mask, result timing and values,
// busy windows, frame drops and reset behaviour; every cycle is compared.
module tb_skin_centroid_tracker;
    localparam int H     = 5;
    localparam int V     = 3;
    localparam int DW    = 8;
    localparam int MINC  = 3;
    localparam int XW    = $clog2(H);
    localparam int YW    = $clog2(V);
    localparam int CW    = $clog2(H*V+1);
    localparam int SXW   = XW + CW;
    localparam int SYW   = YW + CW;

    logic              clock = 1'b0;
    logic              reset, pix_valid, sof;
    logic [DW-1:0]     R, G, B;
    logic signed [DW:0] thr_lo, thr_hi;
    logic              mask, mask_valid, found, result_valid, busy, frame_drop;
    logic [XW-1:0]     cen_x;
    logic [YW-1:0]     cen_y;
    logic [CW-1:0]     pix_count;

    skin_centroid_tracker #(.H_ACTIVE(H), .V_ACTIVE(V), .DATA_W(DW), .MIN_COUNT(MINC)) dut (
        .clock(clock), .reset(reset), .pix_valid(pix_valid), .sof(sof),
        .R(R), .G(G), .B(B), .thr_lo(thr_lo), .thr_hi(thr_hi),
        .mask(mask), .mask_valid(mask_valid), .cen_x(cen_x), .cen_y(cen_y),
        .pix_count(pix_count), .found(found), .result_valid(result_valid),
        .busy(busy), .frame_drop(frame_drop));

    always #5 clock = ~clock;

    int n_vec = 0, n_err = 0, cyc = 0;

    // Reference model state
    int m_col = 0, m_row = 0, m_tlo = 0, m_thi = 0;
    int xs[$], ys[$];
    int busy_lo = 0, busy_hi = -1, drop_cyc = -1, res_cyc = -1;
    bit pend = 0, p_found = 0;
    int p_cx = 0, p_cy = 0, p_cnt = 0;
    int e_cx = 0, e_cy = 0, e_cnt = 0;
    bit e_found = 0, e_mask = 0, n_mv = 0, n_mask = 0, n_ld = 0;

    // Stimulus state
    int dens = 40, f_tl = 10, f_th = 74;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", tag, cyc, got, exp);
        end
    endtask

    task automatic model(input bit rs, input bit pv, input bit sf, input int r, input int g,
                         input int tl, input int th);
        int diff, n, sx, sy;
        bit sk, eof;
        if (rs) begin
            m_col = 0; m_row = 0; m_tlo = 0; m_thi = 0;
            xs.delete(); ys.delete();
            busy_lo = 0; busy_hi = -1; drop_cyc = -1; pend = 0;
            e_cx = 0; e_cy = 0; e_cnt = 0; e_found = 0;
            n_mv = 0; n_mask = 0; n_ld = 1;
            return;
        end
        n_mv = pv; n_ld = pv;
        if (!pv) return;
        if (sf) begin m_col = 0; m_row = 0; xs.delete(); ys.delete(); end
        if (m_col == 0 && m_row == 0) begin m_tlo = tl; m_thi = th; end
        diff = r - g;
        sk = (diff > m_tlo) && (diff < m_thi);
        n_mask = sk;
        if (sk) begin xs.push_back(m_col); ys.push_back(m_row); end
        eof = (m_col == H-1) && (m_row == V-1);
        if (m_col == H-1) begin
            m_col = 0;
            m_row = (m_row == V-1) ? 0 : m_row + 1;
        end else m_col++;
        if (eof) begin
            if (cyc >= busy_lo && cyc <= busy_hi) drop_cyc = cyc + 1;
            else begin
                n = xs.size(); sx = 0; sy = 0;
                foreach (xs[i]) begin sx += xs[i]; sy += ys[i]; end
                busy_lo = cyc + 1;
                p_cnt = n; pend = 1;
                if (n < MINC || n == 0) begin
                    busy_hi = cyc + 2; res_cyc = cyc + 2; p_found = 0;
                end else begin
                    busy_hi = cyc + 2 + SXW + SYW; res_cyc = busy_hi + 1; p_found = 1;
                    p_cx = sx / n; p_cy = sy / n;
                end
            end
            xs.delete(); ys.delete();
        end
    endtask

    task automatic check_outputs();
        bit rv;
        rv = pend && (res_cyc == cyc);
        if (rv) begin
            pend = 0; e_cnt = p_cnt; e_found = p_found;
            if (p_found) begin e_cx = p_cx; e_cy = p_cy; end
        end
        if (n_ld) e_mask = n_mask;
        check_val("mask_valid",   32'(mask_valid),   32'(n_mv));
        check_val("mask",         32'(mask),         32'(e_mask));
        check_val("result_valid", 32'(result_valid), 32'(rv));
        check_val("busy",         32'(busy),         32'(cyc >= busy_lo && cyc <= busy_hi));
        check_val("frame_drop",   32'(frame_drop),   32'(drop_cyc == cyc));
        check_val("cen_x",        32'(cen_x),        32'(e_cx));
        check_val("cen_y",        32'(cen_y),        32'(e_cy));
        check_val("pix_count",    32'(pix_count),    32'(e_cnt));
        check_val("found",        32'(found),        32'(e_found));
    endtask

    task automatic step(input bit rs, input bit pv, input bit sf, input int r, input int g,
                        input int b, input int tl, input int th);
        reset = rs; pix_valid = pv; sof = sf;
        R = 8'(r); G = 8'(g); B = 8'(b);
        thr_lo = 9'(tl); thr_hi = 9'(th);
        model(rs, pv, sf, r, g, tl, th);
        @(posedge clock); #1; cyc++;
        check_outputs();
    endtask

    task automatic rand_step(input int pv_pct, input int sof_pct, input int rst_pct);
        bit pv, sf, rs, origin;
        int r, g, tl, th;
        rs = ($urandom_range(999) < 10 * rst_pct);
        pv = ($urandom_range(99) < pv_pct);
        sf = pv && ($urandom_range(99) < sof_pct);
        origin = sf || (m_col == 0 && m_row == 0);
        if (pv && origin) begin
            if (!sf) sf = $urandom_range(1) == 1;
            case ($urandom_range(3))
                0: dens = 0;
                1: dens = 8;
                2: dens = 40;
                default: dens = 90;
            endcase
            if ($urandom_range(3) != 0) begin f_tl = 10; f_th = 74; end
            else begin
                f_tl = int'($urandom_range(511)) - 256;
                f_th = int'($urandom_range(511)) - 256;
            end
        end
        if ($urandom_range(99) < dens) begin
            g = $urandom_range(150);
            r = g + $urandom_range(73, 11);
        end else begin
            r = $urandom_range(255);
            g = $urandom_range(255);
        end
        tl = origin ? f_tl : int'($urandom_range(511)) - 256;
        th = origin ? f_th : int'($urandom_range(511)) - 256;
        step(rs, pv, sf, r, g, $urandom_range(255), tl, th);
    endtask

    initial begin
        int guard;
        reset = 1'b1; pix_valid = 1'b0; sof = 1'b0;
        R = '0; G = '0; B = '0; thr_lo = '0; thr_hi = '0;
        repeat (3) step(1, 0, 0, 0, 0, 0, 0, 0);

        // Out-of-window high, out-of-window low, then in-window
        dens = 40; f_tl = 10; f_th = 74;
        step(0, 1, 1, 100, 20, 7, 10, 74);
        step(0, 1, 0, 20, 100, 7, -200, 200);
        step(0, 1, 0, 60, 20, 7, 100, -100);

        for (int ph = 0; ph < 8; ph++) begin
            int pvp, sfp;
            pvp = (ph % 4 < 2) ? 100 : ((ph % 4 == 2) ? 60 : 35);
            sfp = (ph >= 4) ? 3 : 0;
            repeat (300) rand_step(pvp, sfp, 0);
        end

        // Reset landing inside the y division of an accepted frame
        guard = 0;
        while (!(pend && p_found && cyc == res_cyc - 3) && guard < 600) begin
            rand_step(60, 0, 0);
            guard++;
        end
        if (guard >= 600) check_val("divy_wait", 32'(0), 32'(1));
        else step(1, 0, 0, 0, 0, 0, 0, 0);
        repeat (200) rand_step(100, 0, 0);

        repeat (400) rand_step(70, 2, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
